// File: rtl/prio_enc_seq_if.sv
// rtl/prio_enc_seq_if.sv - request/index handshake bundle for prio_enc_seq
interface prio_enc_seq_if #(
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req_in;
    logic             req_vld;
    logic             req_rdy;
    logic [IDX_W-1:0] idx_out;
    logic             idx_vld;
    logic             idx_rdy;
    logic [IDX_W:0]   pend_cnt;
    logic             zero_err;

    modport master (
        output req_in, req_vld, idx_rdy,
        input  req_rdy, idx_out, idx_vld, pend_cnt, zero_err
    );

    modport slave (
        input  req_in, req_vld, idx_rdy,
        output req_rdy, idx_out, idx_vld, pend_cnt, zero_err
    );
endinterface

// File: rtl/prio_enc_seq.sv
// rtl/prio_enc_seq.sv - sequential multi-hot to index encoder; ROUND_ROBIN_EN selects rotating priority
module prio_enc_seq #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_enc_seq_if.slave bus
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W:0]   pend_cnt_q, pend_cnt_d;
    logic             zero_err_q, zero_err_d;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   req_pop;
`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

    always_comb begin
        req_pop = '0;
        for (int i = 0; i < N; i++) begin
            req_pop = req_pop + (IDX_W+1)'(bus.req_in[IDX_W'(i)]);
        end
    end

    // Selection is decoded from the registered pending word only, so idx_out cannot glitch on inputs.
`ifdef ROUND_ROBIN_EN
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        int               j;
        sel_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            cand = IDX_W'(j);
            if (!found && pending_q[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[IDX_W'(i)]) sel_idx = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            pend_cnt_q <= '0;
            zero_err_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            zero_err_q <= zero_err_d;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pend_cnt_d = pend_cnt_q;
        zero_err_d = 1'b0;
`ifdef ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_vld) begin
                    if (bus.req_in != '0) begin
                        pending_d  = bus.req_in;
                        pend_cnt_d = req_pop;
                        state_d    = SCAN;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.idx_rdy) begin
                    pending_d  = pending_q & ~(N'(1) << sel_idx);
                    pend_cnt_d = pend_cnt_q - (IDX_W+1)'(1);
`ifdef ROUND_ROBIN_EN
                    ptr_d = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);
`endif
                    if (pend_cnt_q == (IDX_W+1)'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy  = (state_q == IDLE);
        bus.idx_vld  = (state_q == SCAN);
        bus.idx_out  = (state_q == SCAN) ? sel_idx : '0;
        bus.pend_cnt = pend_cnt_q;
        bus.zero_err = zero_err_q;
    end
endmodule

// File: tb/tb_prio_enc_seq.sv
// tb/tb_prio_enc_seq.sv - scoreboard bench for prio_enc_seq (N=8); honours ROUND_ROBIN_EN
module tb_prio_enc_seq;
    typedef struct {
        int idx;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    prio_enc_seq_if #(.N(8)) bus ();

    prio_enc_seq #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int cnt);
        exp_t e;
        e.idx = idx;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.idx_vld && bus.idx_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_idx", int'(bus.idx_out), -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("idx_out", int'(bus.idx_out), e.idx);
                chk("pend_cnt", int'(bus.pend_cnt), e.cnt);
            end
        end
    end

    task automatic load(input logic [7:0] w);
        @(posedge clk);
        #1;
        bus.req_in  = w;
        bus.req_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!bus.req_rdy) begin
            cyc++;
            if (cyc > 50) begin
                chk("idle_timeout", cyc, -1);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        bus.req_in  = '0;
        bus.req_vld = 1'b0;
        bus.idx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_rdy", int'(bus.req_rdy), 1);
        chk("rst_idx_vld", int'(bus.idx_vld), 0);
        chk("rst_idx_out", int'(bus.idx_out), 0);
        chk("rst_pend_cnt", int'(bus.pend_cnt), 0);
        chk("rst_zero_err", int'(bus.zero_err), 0);

        // Reset while scanning
        load(8'b1010_0110);
        @(negedge clk);
        chk("pre_rst_vld", int'(bus.idx_vld), 1);
        chk("pre_rst_cnt", int'(bus.pend_cnt), 4);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_idx_vld", int'(bus.idx_vld), 0);
        chk("midrst_req_rdy", int'(bus.req_rdy), 1);
        chk("midrst_pend_cnt", int'(bus.pend_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.idx_rdy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stale_idx_vld", int'(bus.idx_vld), 0);
        end

        // One-hot sweep
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'b1 << i;
            push(i, 1);
            load(w);
            wait_idle(cyc);
            chk("onehot_cycles", cyc, 1);
        end
        chk("sweep_sb_empty", sb.size(), 0);

        // Multi-hot, back-to-back handshakes
        push(1, 4); push(2, 3); push(5, 2); push(7, 1);
        load(8'b1010_0110);
        wait_idle(cyc);
        chk("multi_cycles", cyc, 4);
        chk("multi_sb_empty", sb.size(), 0);
        chk("multi_pend_end", int'(bus.pend_cnt), 0);

        // Backpressure with an ignored req_vld during SCAN
        bus.idx_rdy = 1'b0;
        load(8'b1010_0110);
        bus.req_in  = 8'hFF;
        bus.req_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_idx_vld", int'(bus.idx_vld), 1);
            chk("bp_idx_out", int'(bus.idx_out), 1);
            chk("bp_pend_cnt", int'(bus.pend_cnt), 4);
            chk("bp_req_rdy", int'(bus.req_rdy), 0);
        end
        @(posedge clk);
        #1;
        bus.req_vld = 1'b0;
        push(1, 4); push(2, 3); push(5, 2); push(7, 1);
        bus.idx_rdy = 1'b1;
        wait_idle(cyc);
        chk("bp_cycles", cyc, 4);
        chk("bp_sb_empty", sb.size(), 0);

        // Zero word
        load(8'h00);
        @(negedge clk);
        chk("zero_err_pulse", int'(bus.zero_err), 1);
        chk("zero_idx_vld", int'(bus.idx_vld), 0);
        chk("zero_req_rdy", int'(bus.req_rdy), 1);
        @(negedge clk);
        chk("zero_err_clear", int'(bus.zero_err), 0);
        chk("zero_still_idle", int'(bus.req_rdy), 1);

        // Priority order across consecutive words
        push(0, 2); push(1, 1);
        load(8'b0000_0011);
        wait_idle(cyc);
        chk("w03_cycles", cyc, 2);
`ifdef ROUND_ROBIN_EN
        push(7, 3); push(0, 2); push(1, 1);
`else
        push(0, 3); push(1, 2); push(7, 1);
`endif
        load(8'b1000_0011);
        wait_idle(cyc);
        chk("w83_cycles", cyc, 3);
        chk("order_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
